// File: rtl/tail_light_if.sv
// Driver-switch requests and lamp/status outputs of the tail-light sequencer.
interface tail_light_if #(
    parameter int LAMPS = 3
);
    logic                 left;
    logic                 right;
    logic                 hazard;
    logic                 brake;
    logic [2*LAMPS-1:0]   y;
    logic                 busy;
    logic [1:0]           mode;

    modport master (
        output left, right, hazard, brake,
        input  y, busy, mode
    );

    modport slave (
        input  left, right, hazard, brake,
        output y, busy, mode
    );
endinterface

// File: rtl/tail_light_seq.sv
// Turn/hazard/brake tail-light sequencer: outward-growing lamp pattern per side,
// hazard preempting turns, and a brake overlay on groups not used by the sequence.
module tail_light_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    tail_light_if.slave  bus
);

    localparam int SW = (LAMPS > 1) ? $clog2(LAMPS + 1) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEFT  = 3'd1,
        S_RIGHT = 3'd2,
        S_HAZ   = 3'd3,
        S_OFF   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    state_t          adv_state_s;
    logic [SW-1:0]   adv_step_s;
    logic [CW-1:0]   adv_cnt_s;

    logic [LAMPS-1:0] pat_l_s, pat_r_s, grp_l_s, grp_r_s, brake_grp_s;
    logic [1:0]       mode_s;
    logic             busy_s;

    // State, step and tick counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            step_q  <= STEP_ONE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Step advance shared by LEFT, RIGHT and HAZ; the last step hands over to OFF
    always_comb begin
        adv_state_s = state_q;
        adv_step_s  = step_q;
        adv_cnt_s   = CNT_ZERO;
        if (cnt_q == CNT_LAST) begin
            if (step_q < STEP_LAST) begin
                adv_step_s = step_q + STEP_ONE;
            end else begin
                adv_state_s = S_OFF;
                adv_step_s  = STEP_ONE;
            end
        end else begin
            adv_cnt_s = cnt_q + CNT_ONE;
        end
    end

    // Next-state selection with hazard preemption of turns and the dark gap
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                step_d = STEP_ONE;
                cnt_d  = CNT_ZERO;
                if (bus.hazard || (bus.left && bus.right)) begin
                    state_d = S_HAZ;
                end else if (bus.left) begin
                    state_d = S_LEFT;
                end else if (bus.right) begin
                    state_d = S_RIGHT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEFT, S_RIGHT: begin
                if (bus.hazard) begin
                    state_d = S_HAZ;
                    step_d  = STEP_ONE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = adv_state_s;
                    step_d  = adv_step_s;
                    cnt_d   = adv_cnt_s;
                end
            end
            S_HAZ: begin
                state_d = adv_state_s;
                step_d  = adv_step_s;
                cnt_d   = adv_cnt_s;
            end
            S_OFF: begin
                step_d = STEP_ONE;
                if (bus.hazard) begin
                    state_d = S_HAZ;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = STEP_ONE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Lamp pattern for the current step; left grows upward, right grows downward from centre
    always_comb begin
        pat_l_s = {LAMPS{1'b0}};
        pat_r_s = {LAMPS{1'b0}};
        for (int i = 0; i < LAMPS; i++) begin
            pat_l_s[i]           = (SW'(i) < step_q);
            pat_r_s[LAMPS-1-i]   = (SW'(i) < step_q);
        end
    end

    assign brake_grp_s = bus.brake ? {LAMPS{1'b1}} : {LAMPS{1'b0}};

    // Output decode of registered state; brake fills groups the sequence does not own
    always_comb begin
        grp_l_s = brake_grp_s;
        grp_r_s = brake_grp_s;
        mode_s  = 2'd0;
        busy_s  = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_s = 1'b0;
            end
            S_LEFT: begin
                grp_l_s = pat_l_s;
                mode_s  = 2'd1;
            end
            S_RIGHT: begin
                grp_r_s = pat_r_s;
                mode_s  = 2'd2;
            end
            S_HAZ: begin
                grp_l_s = pat_l_s;
                grp_r_s = pat_r_s;
                mode_s  = 2'd3;
            end
            S_OFF: begin
                mode_s = 2'd0;
            end
            default: begin
                grp_l_s = {LAMPS{1'b0}};
                grp_r_s = {LAMPS{1'b0}};
            end
        endcase
    end

    assign bus.y    = {grp_l_s, grp_r_s};
    assign bus.mode = mode_s;
    assign bus.busy = busy_s;

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Parametrised turn/hazard/brake tail-light sequencer for the lamp-control path, the next generation of the fixed 3+3-lamp Thunderbird-style sequencer. It drives LAMPS lamps per side with a progressive outward-growing pattern and a programmable step period. It adds a hazard mode that preempts turns, a brake overlay, and status outputs. Sits between the debounced driver switches and the lamp drivers.

## Interface
- LAMPS, 3: lamps per side, >= 1.
- TICK_DIV, 4: clock cycles per sequence step, >= 1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- left  in  1  left turn request, level.
- right  in  1  right turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake pedal, level.
- y  out  2*LAMPS  lamps; y[2*LAMPS-1:LAMPS] left group, y[LAMPS-1:0] right group.
- busy  out  1  high whenever state != IDLE.
- mode  out  2  0 idle/off, 1 left, 2 right, 3 hazard.

## Operation
- States: IDLE, LEFT, RIGHT, HAZ, OFF; registers: step (1..LAMPS), tick counter cnt (0..TICK_DIV-1), widths $clog2 of range, minimum 1 bit.
- IDLE, every cycle, priority: hazard, or left&&right -> HAZ; else left -> LEFT; else right -> RIGHT; else stay. Entry sets step=1, cnt=0.
- LEFT/RIGHT/HAZ: cnt increments each cycle; when cnt==TICK_DIV-1: cnt<=0; if step<LAMPS then step<=step+1 else go to OFF.
- OFF: all turn lamps dark for TICK_DIV cycles, then IDLE. One OFF period is always inserted between sequences, so a held request re-runs with a dark gap.
- Preemption: in LEFT, RIGHT or OFF, hazard=1 -> HAZ next cycle with step=1, cnt=0. HAZ is never preempted. A turn request during LEFT/RIGHT/OFF is otherwise ignored; the running sequence completes.
- Pattern for step k, lit lamps grow outward from centre:
  - left group: bits LAMPS..LAMPS+k-1 set.
  - right group: bits LAMPS-1 down to LAMPS-k set.
  - HAZ lights both groups at step k.
- LAMPS=3 example: left 001/011/111 in the upper group; right 100/110/111 in the lower group.
- Brake overlay, combinational from the brake input:
  - any group not used by the active sequence is fully lit while brake=1. That is both groups in IDLE/OFF, the right group in LEFT, and the left group in RIGHT.
  - HAZ ignores brake.
- y, busy and mode are decodes of the registered state plus brake; no other input reaches y combinationally.
- mode: LEFT=1, RIGHT=2, HAZ=3, IDLE/OFF=0.

## Timing
- Reset asserted (low): state=IDLE, step=1, cnt=0 immediately. Outputs: busy=0, mode=0, y=0 (all ones if brake=1).
- Reset mid-sequence aborts it at once; the sequence restarts only from IDLE after release.
- Request latency: a request sampled high in IDLE at edge n gives step-1 pattern on y after edge n. Each step lasts exactly TICK_DIV cycles.
- Full sequence occupies LAMPS*TICK_DIV cycles, then OFF occupies TICK_DIV cycles. IDLE re-evaluates on the following edge.
- TICK_DIV=1: step advances every cycle, with cnt held at 0.
- LAMPS=1: a single step, then OFF.
- A request pulse of one cycle in IDLE is sufficient; requests are not latched outside IDLE.

## Test plan
- LAMPS=3, TICK_DIV=2; reset low with brake=0 -> y=000000, busy=0, mode=0. Release reset, pulse left 1 cycle -> y=001000,001000,011000,011000,111000,111000, then 000000 for 2 cycles, then IDLE; mode=1 during the 6 sequence cycles.
- Same config, left=right=1 held -> HAZ: y=001100 x2, 011110 x2, 111111 x2, 000000 x2, then the sequence repeats; mode=3.
- Right sequence at step 2 (y=000110), raise hazard -> next cycle y=001100, mode=3, full hazard sequence follows.
- Left sequence with brake=1 -> y=001111, 011111, 111111 per step. Brake in IDLE -> 111111; brake during HAZ -> pattern unchanged.
- Assert reset low at left step 2 -> y=000000 and busy=0 asynchronously; after release with no request, stays IDLE.
- LAMPS=1, TICK_DIV=1 and LAMPS=5, TICK_DIV=3: right request -> patterns 1 then 0 / 10000,11000,11100,11110,11111, each held TICK_DIV cycles, followed by a TICK_DIV-cycle dark gap.
